// File: rtl/pkt_filter_passthrough.sv
// Buffered passthrough stage: FIFO with packet-granular drop mode, per-packet counters,
// and a UDP register ring slave for control and statistics.
module pkt_filter_passthrough #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int UDP_REG_SRC_WIDTH   = 2,
    parameter int FIFO_DEPTH_BITS     = 4,
    parameter int CNT_WIDTH           = 32,
    parameter int UDP_REG_ADDR_WIDTH  = 23,
    parameter int CPCI_NF2_DATA_WIDTH = 32,
    parameter int REG_BLOCK_ADDR      = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [CTRL_WIDTH-1:0]          in_ctrl,
    input  logic                           in_wr,
    output logic                           in_rdy,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    output logic                           out_wr,
    input  logic                           out_rdy,
    input  logic                           reg_req_in,
    input  logic                           reg_ack_in,
    input  logic                           reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
    output logic                           reg_req_out,
    output logic                           reg_ack_out,
    output logic                           reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [UDP_REG_ADDR_WIDTH-3:0] BLOCK_TAG = (UDP_REG_ADDR_WIDTH-2)'(REG_BLOCK_ADDR);

    typedef enum logic {HDR, PAYLOAD} parse_state_t;

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]       wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]         count, count_next;
    parse_state_t                     state;
    logic                             sop_pending, pkt_drop, drop_en;
    logic [CNT_WIDTH-1:0]             pass_pkts, drop_pkts, words;

    logic accept, is_sop, is_eop, cur_drop, fifo_wr, fifo_rd;
    logic reg_hit, ctrl_wr, clear;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_rd_data;

    // The drop decision of the packet in flight is latched at SOP; later words reuse it.
    assign accept   = in_wr && in_rdy;
    assign is_sop   = accept && (state == HDR) && sop_pending;
    assign is_eop   = accept && (state == PAYLOAD) && (in_ctrl != '0);
    assign cur_drop = is_sop ? drop_en : pkt_drop;
    assign fifo_wr  = accept && !cur_drop;
    assign fifo_rd  = out_rdy && (count != '0);

    assign reg_hit = reg_req_in && !reg_ack_in && (reg_addr_in[UDP_REG_ADDR_WIDTH-1:2] == BLOCK_TAG);
    assign ctrl_wr = reg_hit && !reg_rd_wr_L_in && (reg_addr_in[1:0] == 2'd0);
    assign clear   = ctrl_wr && reg_data_in[1];

    always_comb begin
        count_next = count;
        if (fifo_wr && !fifo_rd)
            count_next = count + (FIFO_DEPTH_BITS+1)'(1);
        else if (!fifo_wr && fifo_rd)
            count_next = count - (FIFO_DEPTH_BITS+1)'(1);
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_addr_in[1:0])
            2'd0:    reg_rd_data = CPCI_NF2_DATA_WIDTH'(drop_en);
            2'd1:    reg_rd_data = CPCI_NF2_DATA_WIDTH'(pass_pkts);
            2'd2:    reg_rd_data = CPCI_NF2_DATA_WIDTH'(drop_pkts);
            default: reg_rd_data = CPCI_NF2_DATA_WIDTH'(words);
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= {in_ctrl, in_data};
    end

    // in_rdy is registered from the next occupancy so it is exact at every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_rdy   <= 1'b0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            count  <= count_next;
            in_rdy <= count_next <= (FIFO_DEPTH_BITS+1)'(DEPTH - 2);
            out_wr <= fifo_rd;
            if (fifo_wr)
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            if (fifo_rd) begin
                rd_ptr                <= rd_ptr + FIFO_DEPTH_BITS'(1);
                {out_ctrl, out_data} <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HDR;
            sop_pending <= 1'b1;
            pkt_drop    <= 1'b0;
        end else if (accept) begin
            pkt_drop <= cur_drop;
            if (state == HDR) begin
                sop_pending <= 1'b0;
                if (in_ctrl == '0)
                    state <= PAYLOAD;
            end else if (in_ctrl != '0) begin
                state       <= HDR;
                sop_pending <= 1'b1;
            end
        end
    end

    // A clear in the same cycle as an increment wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_pkts <= '0;
            drop_pkts <= '0;
            words     <= '0;
        end else if (clear) begin
            pass_pkts <= '0;
            drop_pkts <= '0;
            words     <= '0;
        end else begin
            if (is_eop && !cur_drop)
                pass_pkts <= pass_pkts + CNT_WIDTH'(1);
            if (is_eop && cur_drop)
                drop_pkts <= drop_pkts + CNT_WIDTH'(1);
            if (fifo_wr)
                words <= words + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_en         <= 1'b0;
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            if (ctrl_wr)
                drop_en <= reg_data_in[0];
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in || reg_hit;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_src_out     <= reg_src_in;
            reg_data_out    <= (reg_hit && reg_rd_wr_L_in) ? reg_rd_data : reg_data_in;
        end
    end

endmodule

// File: tb/tb_pkt_filter_passthrough.sv
// Scoreboard bench for pkt_filter_passthrough: a packet-level model predicts forwarded
// words and counter values; the output monitor pops and compares every out_wr word.
module tb_pkt_filter_passthrough;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b0;
    logic        reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
    logic [22:0] reg_addr_in = '0;
    logic [31:0] reg_data_in = '0;
    logic [1:0]  reg_src_in = '0;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;

    pkt_filter_passthrough dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_count = 0;
    int first_out_cyc = 0;
    bit arm_latency = 0;
    logic [71:0] sb_q[$];

    // Packet model: parser state, drop latch, counters.
    bit m_payload = 0, m_sop_pend = 1, m_pkt_drop = 0, m_drop_en = 0;
    int m_pass = 0, m_drop = 0, m_words = 0;

    task automatic check_output(input string tag, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (out_wr) begin
            out_count++;
            if (arm_latency) begin
                first_out_cyc = cyc;
                arm_latency = 0;
            end
            if (sb_q.size() == 0)
                check_output("sb_nonempty_on_out", 96'(sb_q.size()), 96'd1);
            else
                check_output("out_word", 96'({out_ctrl, out_data}), 96'(sb_q.pop_front()));
        end
    end

    task automatic model_accept(input logic [7:0] ctrl, input logic [63:0] data);
        bit sop = !m_payload && m_sop_pend;
        bit d = sop ? m_drop_en : m_pkt_drop;
        if (!m_payload) begin
            m_sop_pend = 0;
            if (ctrl == 8'h00) m_payload = 1;
        end else if (ctrl != 8'h00) begin
            m_payload = 0;
            m_sop_pend = 1;
            if (d) m_drop++; else m_pass++;
        end
        m_pkt_drop = d;
        if (!d) begin
            sb_q.push_back({ctrl, data});
            m_words++;
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_payload = 0; m_sop_pend = 1; m_pkt_drop = 0; m_drop_en = 0;
        m_pass = 0; m_drop = 0; m_words = 0;
    endtask

    // Drives one word at the next negedge where in_rdy is high; in_wr stays up until the next call.
    task automatic apply_stimulus(input logic [7:0] ctrl, input logic [63:0] data);
        int waited = 0;
        @(negedge clk);
        while (!in_rdy && waited < 200) begin
            in_wr = 1'b0;
            waited++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            check_output("in_rdy_timeout", 96'(in_rdy), 96'd1);
            in_wr = 1'b0;
            return;
        end
        in_wr = 1'b1; in_ctrl = ctrl; in_data = data;
        model_accept(ctrl, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_wr = 1'b0;
        end
    endtask

    task automatic reg_access(input logic rd_wr_L, input logic [22:0] addr, input logic [31:0] wdata,
                              input logic ack_in, input logic [1:0] src,
                              output logic ack_out, output logic [31:0] rdata);
        @(negedge clk);
        in_wr = 1'b0;
        reg_req_in = 1'b1; reg_rd_wr_L_in = rd_wr_L; reg_addr_in = addr;
        reg_data_in = wdata; reg_ack_in = ack_in; reg_src_in = src;
        @(negedge clk);
        ack_out = reg_ack_out;
        rdata = reg_data_out;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    endtask

    task automatic write_ctrl(input logic [31:0] val);
        logic a;
        logic [31:0] d;
        reg_access(1'b0, 23'd0, val, 1'b0, 2'd0, a, d);
        check_output("ctrl_write_ack", 96'(a), 96'd1);
        m_drop_en = val[0];
        if (val[1]) begin m_pass = 0; m_drop = 0; m_words = 0; end
    endtask

    task automatic read_reg(input string tag, input logic [1:0] idx, input int expected);
        logic a;
        logic [31:0] d;
        reg_access(1'b1, {21'd0, idx}, 32'h0, 1'b0, 2'd1, a, d);
        check_output({tag, "_ack"}, 96'(a), 96'd1);
        check_output(tag, 96'(d), 96'(expected));
    endtask

    task automatic send_pkt(input logic [63:0] base);
        apply_stimulus(8'hFF, base);
        apply_stimulus(8'h00, base + 1);
        apply_stimulus(8'h00, base + 2);
        apply_stimulus(8'h01, base + 3);
    endtask

    initial begin
        int in_cyc, acc, out_before;
        logic a;
        logic [31:0] d;

        #12;
        check_output("rst_in_rdy", 96'(in_rdy), 96'd0);
        check_output("rst_out_wr", 96'(out_wr), 96'd0);
        check_output("rst_out_data", 96'({out_ctrl, out_data}), 96'd0);
        check_output("rst_reg_out", 96'({reg_req_out, reg_ack_out, reg_data_out}), 96'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("in_rdy_after_rst", 96'(in_rdy), 96'd1);

        $display("[TB] single packet forward");
        out_rdy = 1'b1;
        arm_latency = 1;
        apply_stimulus(8'hFF, 64'h1111_0000_0000_0000);
        in_cyc = cyc;
        apply_stimulus(8'h00, 64'h1111_0000_0000_0001);
        apply_stimulus(8'h00, 64'h1111_0000_0000_0002);
        apply_stimulus(8'h01, 64'h1111_0000_0000_0003);
        idle(10);
        check_output("latency", 96'(first_out_cyc - in_cyc), 96'd2);
        read_reg("pass_pkts_1", 2'd1, m_pass);
        read_reg("words_1", 2'd3, m_words);
        check_output("pass_pkts_1_const", 96'(m_pass), 96'd1);

        $display("[TB] drop mode, three packets");
        write_ctrl(32'h3);
        read_reg("ctrl_readback", 2'd0, 1);
        out_before = out_count;
        for (int p = 0; p < 3; p++) send_pkt(64'h2000 + 64'(p * 16));
        idle(10);
        check_output("drop_no_out", 96'(out_count - out_before), 96'd0);
        read_reg("drop_pkts", 2'd2, m_drop);
        read_reg("pass_pkts_2", 2'd1, m_pass);
        read_reg("words_2", 2'd3, m_words);

        $display("[TB] mode change mid packet");
        write_ctrl(32'h0);
        apply_stimulus(8'hFF, 64'hA0);
        apply_stimulus(8'h00, 64'hA1);
        write_ctrl(32'h1);
        apply_stimulus(8'h00, 64'hA2);
        apply_stimulus(8'h01, 64'hA3);
        send_pkt(64'hB0);
        idle(10);
        read_reg("pass_pkts_3", 2'd1, m_pass);
        read_reg("drop_pkts_3", 2'd2, m_drop);

        $display("[TB] fifo fill with out_rdy low");
        write_ctrl(32'h0);
        idle(5);
        out_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                in_wr = 1'b1;
                in_ctrl = (acc == 0) ? 8'hFF : 8'h00;
                in_data = 64'h3000 + 64'(i);
                model_accept(in_ctrl, in_data);
                acc++;
            end else begin
                in_wr = 1'b0;
            end
        end
        idle(1);
        check_output("fill_accepted", 96'(acc), 96'd15);
        check_output("fill_in_rdy", 96'(in_rdy), 96'd0);
        out_rdy = 1'b1;
        apply_stimulus(8'h01, 64'h30FF);
        idle(30);
        check_output("fill_drained", 96'(sb_q.size()), 96'd0);

        $display("[TB] register ring passthrough");
        reg_access(1'b1, 23'd1, 32'hDEAD_BEEF, 1'b1, 2'd2, a, d);
        check_output("ring_acked_ack", 96'(a), 96'd1);
        check_output("ring_acked_data", 96'(d), 96'hDEAD_BEEF);
        reg_access(1'b1, 23'h4_0001, 32'hCAFE_F00D, 1'b0, 2'd3, a, d);
        check_output("ring_nomatch_ack", 96'(a), 96'd0);
        check_output("ring_nomatch_data", 96'(d), 96'hCAFE_F00D);
        check_output("ring_nomatch_fields", 96'({reg_req_out, reg_rd_wr_L_out, reg_addr_out, reg_src_out}),
                     96'({1'b1, 1'b1, 23'h4_0001, 2'd3}));
        reg_access(1'b0, 23'd2, 32'h55, 1'b0, 2'd0, a, d);
        check_output("ro_write_ack", 96'(a), 96'd1);
        read_reg("drop_after_ro_write", 2'd2, m_drop);

        $display("[TB] clear coincident with EOP");
        apply_stimulus(8'hFF, 64'hC0);
        apply_stimulus(8'h00, 64'hC1);
        @(negedge clk);
        for (int w = 0; w < 50 && !in_rdy; w++) @(negedge clk);
        check_output("clear_in_rdy", 96'(in_rdy), 96'd1);
        in_wr = 1'b1; in_ctrl = 8'h01; in_data = 64'hC2;
        model_accept(8'h01, 64'hC2);
        reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b0; reg_addr_in = 23'd0; reg_data_in = 32'h2;
        m_pass = 0; m_drop = 0; m_words = 0; m_drop_en = 0;
        @(negedge clk);
        in_wr = 1'b0; reg_req_in = 1'b0; reg_data_in = '0;
        check_output("clear_ack", 96'(reg_ack_out), 96'd1);
        idle(5);
        read_reg("clr_pass", 2'd1, 0);
        read_reg("clr_drop", 2'd2, 0);
        read_reg("clr_words", 2'd3, 0);

        $display("[TB] reset mid packet");
        out_rdy = 1'b0;
        apply_stimulus(8'hFF, 64'hD0);
        apply_stimulus(8'h00, 64'hD1);
        idle(1);
        reset_n = 1'b0;
        #1;
        check_output("midrst_in_rdy", 96'(in_rdy), 96'd0);
        check_output("midrst_out", 96'({out_wr, out_ctrl, out_data}), 96'd0);
        model_reset();
        idle(2);
        reset_n = 1'b1;
        out_rdy = 1'b1;
        send_pkt(64'hE0);
        idle(10);
        read_reg("post_rst_pass", 2'd1, m_pass);
        read_reg("post_rst_words", 2'd3, m_words);

        idle(5);
        check_output("sb_empty_end", 96'(sb_q.size()), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
